kmouse_packet_engine: RTL
=========================

KMOUSE_PACKET_ENGINE -- requirements
Module: kmouse_packet_engine

Interface
REQ-001 SHALL have parameter CNT_W, default 8, accumulator width per axis in bits (legal range 8..16).
REQ-002 SHALL have parameter TIMEOUT_W, default 20, inter-byte timeout counter width; timeout is 2^TIMEOUT_W clk cycles.
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data  input  8  byte from PS/2 receiver.
REQ-006 SHALL have port data_valid  input  1  one-cycle strobe qualifying data.
REQ-007 SHALL have port sens  input  2  sensitivity shift, 0..3.
REQ-008 SHALL have port clr  input  1  one-cycle strobe zeroing X/Y/wheel accumulators.
REQ-009 SHALL have port kmouse_x  output  8  X position, accumulator bits [CNT_W-1 -: 8].
REQ-010 SHALL have port kmouse_y  output  8  Y position, accumulator bits [CNT_W-1 -: 8].
REQ-011 SHALL have port kmouse_buttons  output  8  Kempston buttons: bit0 right, bit1 left, bit2 middle, active-low; bits 7:4 wheel.
REQ-012 SHALL have port pkt_done  output  1  one-cycle strobe when a complete packet is applied.
REQ-013 SHALL have port sync_err  output  1  one-cycle strobe on discarded byte or timeout.

Function
REQ-014 FSM states: IDLE (await byte0), B1, B2, B3 (B3 only with wheel); advance once per data_valid.
REQ-015 In IDLE, a byte with bit3=0 SHALL be discarded, sync_err pulsed, state stays IDLE.
REQ-016 In IDLE, a byte with bit3=1 SHALL be latched as header (buttons, sign, overflow bits), next state B1.
REQ-017 B1 byte SHALL be latched as X delta low 8 bits, next state B2.
REQ-018 B2 byte SHALL be latched as Y delta low 8 bits; without wheel, the packet is applied and state returns to IDLE.
REQ-019 With wheel, B3 byte bits [3:0] SHALL be the signed wheel delta; the packet is applied, state returns to IDLE.
REQ-020 Packet apply: delta = {sign, byte} as 9-bit two's complement, sign-extended to CNT_W+1, arithmetically right-shifted by sens.
REQ-021 An axis whose header overflow bit (X: bit6, Y: bit7) is set SHALL receive zero delta for that packet.
REQ-022 Accumulators SHALL add the delta modulo 2^CNT_W; wrap-around in both directions is legal and silent.
REQ-023 Y SHALL be added unnegated (PS/2 up = positive = Kempston up).
REQ-024 Buttons SHALL update on packet apply only: bit0 = ~hdr[1], bit1 = ~hdr[0], bit2 = ~hdr[2].
REQ-025 Outputs SHALL change on the clk edge after the final byte's data_valid (latency 1); pkt_done SHALL pulse in that same cycle.
REQ-026 If no data_valid arrives for 2^TIMEOUT_W cycles while not in IDLE, the partial packet SHALL be dropped, sync_err pulsed, state set to IDLE.
REQ-027 The timeout counter SHALL reset on every data_valid and hold at zero in IDLE.
REQ-028 A clr coinciding with a packet apply SHALL win for accumulators; buttons still update; pkt_done still pulses.
REQ-029 A change of sens takes effect at the next packet apply only.

Reset
REQ-030 Asserting rst_n low SHALL immediately force state IDLE, accumulators 0, timeout counter 0, pkt_done 0, sync_err 0.
REQ-031 Reset value: kmouse_x = 8'h00, kmouse_y = 8'h00; kmouse_buttons = 8'hFF without wheel, 8'h0F with wheel.
REQ-032 Reset asserted mid-packet SHALL discard the partial packet with no sync_err.

Configuration
REQ-033 Macro KMOUSE_WHEEL_EN defined: 4-byte IntelliMouse packets, state B3 present, 4-bit wrapping wheel accumulator on kmouse_buttons[7:4].
REQ-034 KMOUSE_WHEEL_EN undefined: 3-byte packets, no B3, kmouse_buttons[7:3] constant 1.

Structure
REQ-035 Package kmouse_pkg SHALL hold the FSM state encoding, header bit positions (sync, overflow, sign, buttons) and Kempston button bit positions.
REQ-036 One sub-module kmouse_axis_acc (parameter CNT_W; sign-extend, shift, overflow gate, clr, wrapping add) SHALL be instantiated for X and Y.

Verification
REQ-037 Reset, then bytes 08,05,03 (sens=0) -> x=05, y=03, buttons=FF, one pkt_done.
REQ-038 Bytes 39,FB,00 -> x decreases by 5 modulo 256 (00->FB), buttons bit0/bit1 per header, no Y change.
REQ-039 Byte 00 in IDLE then 08,01,01 -> sync_err on first byte, packet applied correctly afterwards.
REQ-040 Bytes 08,10, then idle 2^TIMEOUT_W cycles -> sync_err, no output change; next 08,02,02 -> x=+2.
REQ-041 Header 48 (X overflow), deltas 7F,01 -> x unchanged, y+1; sens=2 with delta 08 -> +2.
REQ-042 KMOUSE_WHEEL_EN: bytes 08,00,00,0F -> buttons[7:4] = F (wheel -1); clr together with final byte -> x=y=0.

Source files
------------

// File: rtl/kmouse_pkg.sv
// Shared definitions for the Kempston mouse packet engine:
// FSM encoding, PS/2 header bit positions, Kempston button bits.
package kmouse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_B1   = 2'd1,
        ST_B2   = 2'd2,
        ST_B3   = 2'd3
    } state_t;

    localparam int HDR_BTN_L  = 0;
    localparam int HDR_BTN_R  = 1;
    localparam int HDR_BTN_M  = 2;
    localparam int HDR_SYNC   = 3;
    localparam int HDR_X_SIGN = 4;
    localparam int HDR_Y_SIGN = 5;
    localparam int HDR_X_OVF  = 6;
    localparam int HDR_Y_OVF  = 7;

    localparam int KM_BTN_R = 0;
    localparam int KM_BTN_L = 1;
    localparam int KM_BTN_M = 2;

    // PS/2 buttons are active-high, Kempston buttons active-low
    function automatic logic [2:0] kempston_btn(input logic [2:0] hbtn);
        logic [2:0] r;
        r           = 3'b111;
        r[KM_BTN_R] = ~hbtn[HDR_BTN_R];
        r[KM_BTN_L] = ~hbtn[HDR_BTN_L];
        r[KM_BTN_M] = ~hbtn[HDR_BTN_M];
        return r;
    endfunction

endpackage

// File: rtl/kmouse_axis_acc.sv
// One position axis: sign-extend the 9-bit PS/2 delta, scale it by
// the sensitivity shift, gate on overflow and add with silent wrap.
module kmouse_axis_acc
    import kmouse_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       apply,
    input  logic       clr,
    input  logic [1:0] sens,
    input  logic       ovf,
    input  logic       sign,
    input  logic [7:0] low,
    output logic [7:0] pos
);

    logic [CNT_W-1:0]   acc;
    logic signed [8:0]  raw;
    logic signed [CNT_W:0] ext;
    logic signed [CNT_W:0] shf;
    logic [CNT_W-1:0]   delta;

    assign raw   = {sign, low};
    assign ext   = (CNT_W+1)'(raw);
    assign shf   = ext >>> sens;
    assign delta = ovf ? '0 : CNT_W'(shf);

    // accumulate; a clear in the same cycle as an apply wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (apply) begin
            acc <= acc + delta;
        end
    end

    assign pos = acc[CNT_W-1 -: 8];

endmodule

// File: rtl/kmouse_packet_engine.sv
// PS/2 mouse packet assembler driving Kempston X/Y/button registers.
// Define KMOUSE_WHEEL_EN for 4-byte IntelliMouse packets with wheel.
module kmouse_packet_engine
    import kmouse_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int TIMEOUT_W = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       data_valid,
    input  logic [1:0] sens,
    input  logic       clr,
    output logic [7:0] kmouse_x,
    output logic [7:0] kmouse_y,
    output logic [7:0] kmouse_buttons,
    output logic       pkt_done,
    output logic       sync_err
);

    state_t state;
    state_t state_nxt;

    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic tmo_hit;

    logic hdr_ld;
    logic x_ld;
    logic y_ld;
    logic apply;
    logic bad_byte;

    logic       x_ovf;
    logic       y_ovf;
    logic       x_sign;
    logic       y_sign;
    logic [2:0] hbtn;
    logic [7:0] x_lo;
    logic [7:0] y_byte;
    logic [2:0] btn;

`ifdef KMOUSE_WHEEL_EN
    logic [7:0] y_lo;
    logic [3:0] wheel;
`endif

    assign tmo_hit = (state != ST_IDLE) && !data_valid && (&tmo_cnt);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: advance once per byte, drop to idle on timeout
    always_comb begin
        state_nxt = state;
        if (data_valid) begin
            unique case (state)
                ST_IDLE: state_nxt = data[HDR_SYNC] ? ST_B1 : ST_IDLE;
                ST_B1:   state_nxt = ST_B2;
`ifdef KMOUSE_WHEEL_EN
                ST_B2:   state_nxt = ST_B3;
`else
                ST_B2:   state_nxt = ST_IDLE;
`endif
                ST_B3:   state_nxt = ST_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_nxt = ST_IDLE;
        end
    end

    // per-state byte strobes: header/X/Y latch, apply, reject
    always_comb begin
        hdr_ld   = 1'b0;
        x_ld     = 1'b0;
        y_ld     = 1'b0;
        apply    = 1'b0;
        bad_byte = 1'b0;
        if (data_valid) begin
            unique case (state)
                ST_IDLE: begin
                    hdr_ld   = data[HDR_SYNC];
                    bad_byte = !data[HDR_SYNC];
                end
                ST_B1: x_ld = 1'b1;
                ST_B2: begin
`ifdef KMOUSE_WHEEL_EN
                    y_ld = 1'b1;
`else
                    apply = 1'b1;
`endif
                end
                ST_B3: begin
`ifdef KMOUSE_WHEEL_EN
                    apply = 1'b1;
`endif
                end
            endcase
        end
    end

    // inter-byte timeout, parked at zero while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_IDLE || data_valid) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
        end
    end

    // header and delta byte capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_ovf  <= 1'b0;
            y_ovf  <= 1'b0;
            x_sign <= 1'b0;
            y_sign <= 1'b0;
            hbtn   <= 3'b000;
            x_lo   <= 8'h00;
        end else begin
            if (hdr_ld) begin
                x_ovf  <= data[HDR_X_OVF];
                y_ovf  <= data[HDR_Y_OVF];
                x_sign <= data[HDR_X_SIGN];
                y_sign <= data[HDR_Y_SIGN];
                hbtn   <= data[2:0];
            end
            if (x_ld) begin
                x_lo <= data;
            end
        end
    end

`ifdef KMOUSE_WHEEL_EN
    // Y byte is held until the wheel byte completes the packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_lo <= 8'h00;
        end else if (y_ld) begin
            y_lo <= data;
        end
    end

    // 4-bit wrapping wheel count; clear wins over apply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wheel <= 4'h0;
        end else if (clr) begin
            wheel <= 4'h0;
        end else if (apply) begin
            wheel <= wheel + data[3:0];
        end
    end

    assign y_byte = y_lo;
`else
    assign y_byte = data;
`endif

    // buttons change only when a full packet lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn <= 3'b111;
        end else if (apply) begin
            btn <= kempston_btn(hbtn);
        end
    end

    // completion and resync strobes, aligned with the output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_done <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            pkt_done <= apply;
            sync_err <= bad_byte | tmo_hit;
        end
    end

    kmouse_axis_acc #(.CNT_W(CNT_W)) u_acc_x (
        .clk   (clk),
        .rst_n (rst_n),
        .apply (apply),
        .clr   (clr),
        .sens  (sens),
        .ovf   (x_ovf),
        .sign  (x_sign),
        .low   (x_lo),
        .pos   (kmouse_x)
    );

    kmouse_axis_acc #(.CNT_W(CNT_W)) u_acc_y (
        .clk   (clk),
        .rst_n (rst_n),
        .apply (apply),
        .clr   (clr),
        .sens  (sens),
        .ovf   (y_ovf),
        .sign  (y_sign),
        .low   (y_byte),
        .pos   (kmouse_y)
    );

`ifdef KMOUSE_WHEEL_EN
    assign kmouse_buttons = {wheel, 1'b1, btn};
`else
    assign kmouse_buttons = {5'b11111, btn};
`endif

endmodule
